cmd_arbiter: RTL and testbench
==============================

CMD_ARBITER -- requirements
Module: cmd_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the RUN-state cycle limit before abort (watchdog builds only).
REQ-002 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cmd0_TDATA  input  29  host debugger command word.
REQ-005 SHALL have port cmd0_TVALID / cmd0_TREADY  input / output  1 each  AXIS handshake, requester 0.
REQ-006 SHALL have port cmd1_TDATA  input  29  trigger-unit command word.
REQ-007 SHALL have port cmd1_TVALID / cmd1_TREADY  input / output  1 each  AXIS handshake, requester 1.
REQ-008 SHALL have port cmd_out_TDATA  output  29  command to control FSM cmd_in.
REQ-009 SHALL have port cmd_out_TVALID / cmd_out_TREADY  output / input  1 each  AXIS handshake to control FSM.
REQ-010 SHALL have port fsm_state  input  10  control FSM curr_state; 0 = START.
REQ-011 SHALL have port grant  output  2  one-hot owner of current operation; 0 when idle.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port timeout_err  output  1  one-cycle pulse on watchdog abort.

Function
REQ-014 SHALL implement states IDLE, CAPTURE, ISSUE, WAIT_START, RUN.
REQ-015 IDLE: if any cmdN_TVALID, SHALL pick winner by round-robin: the requester not granted last wins a tie; single valid requester wins outright.
REQ-016 IDLE: SHALL assert winner's cmdN_TREADY combinationally for exactly that cycle; loser's TREADY stays 0; SHALL register TDATA, set grant, go CAPTURE.
REQ-017 CAPTURE: if captured word == 0, SHALL discard it, clear grant, update last-grant pointer, return IDLE; else go ISSUE.
REQ-018 ISSUE: SHALL drive cmd_out_TVALID=1 with registered data held stable until cmd_out_TREADY; on handshake go WAIT_START.
REQ-019 WAIT_START: when fsm_state != 0 go RUN; if fsm_state stays 0 for 2 consecutive cycles, SHALL treat op as complete (FSM consumed and stayed in START) and return IDLE.
REQ-020 RUN: when fsm_state == 0, SHALL clear grant, update last-grant pointer, return IDLE next cycle.
REQ-021 Latency: accepted command SHALL appear on cmd_out_TVALID 2 cycles after cmdN handshake.
REQ-022 Only one command outstanding; no requester SHALL be accepted outside IDLE.
REQ-023 cmd_out_TVALID SHALL be 0 in every state except ISSUE; TDATA SHALL be 0 when TVALID=0.
REQ-024 Requester dropping TVALID before acceptance SHALL not be granted; no state change.

Reset
REQ-025 On rst: state=IDLE, grant=0, busy=0, cmd_out_TVALID=0, cmd_out_TDATA=0, cmd0/1_TREADY=0, timeout_err=0, last-grant pointer = requester 1 (so requester 0 wins first tie), timeout counter=0.
REQ-026 rst asserted mid-operation SHALL abandon the held command without replay.

Configuration
REQ-027 Macro CMD_ARBITER_TIMEOUT_EN: defined -> counter runs in WAIT_START/RUN, clears on state entry; reaching TIMEOUT_CYCLES SHALL pulse timeout_err, clear grant, return IDLE.
REQ-028 Undefined -> no counter; timeout_err tied 0; RUN waits indefinitely.

Verification
REQ-029 cmd0 valid alone, TDATA=0x0000009, FSM stub goes state 1 for 5 cycles then 0 -> cmd_out 0x0000009 two cycles after accept, grant=01, IDLE after return to 0.
REQ-030 Both valid after reset, cmd0=0x11, cmd1=0x21 -> cmd0 served first, then cmd1; third tie -> cmd0.
REQ-031 cmd1 TDATA=0 -> TREADY pulse, no cmd_out_TVALID, grant clears after CAPTURE.
REQ-032 cmd_out_TREADY held 0 for 10 cycles -> TVALID and TDATA 0x0000009 stable throughout, no new acceptance.
REQ-033 With CMD_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=16, fsm_state stuck at 4 -> timeout_err pulse 16 cycles after RUN entry, busy=0 next cycle.
REQ-034 rst pulsed during RUN -> all outputs at reset values same cycle; held command never reissued.

Source files
------------

// File: rtl/cmd_arbiter.sv
// cmd_arbiter: two-requester round-robin command arbiter in front of a control FSM.
//
// Accepts one AXIS command word from either the host debugger (cmd0) or the
// trigger unit (cmd1), forwards it to the control FSM (cmd_out) and tracks the
// FSM through START -> running -> START before accepting the next command.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   cmd0_TDATA/TVALID/TREADY  requester 0 (host debugger) AXIS slave
//   cmd1_TDATA/TVALID/TREADY  requester 1 (trigger unit) AXIS slave
//   cmd_out_TDATA/TVALID/TREADY  AXIS master towards control FSM cmd_in
//   fsm_state                 control FSM curr_state (0 = START)
//   grant                     one-hot owner of the current operation, 0 when idle
//   busy                      high whenever not IDLE
//   timeout_err               one-cycle pulse on watchdog abort
//
// Optional build: define CMD_ARBITER_TIMEOUT_EN to enable a watchdog that
// aborts an operation after TIMEOUT_CYCLES cycles in WAIT_START/RUN.

module cmd_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [28:0] cmd0_TDATA,
  input  logic        cmd0_TVALID,
  output logic        cmd0_TREADY,
  input  logic [28:0] cmd1_TDATA,
  input  logic        cmd1_TVALID,
  output logic        cmd1_TREADY,
  output logic [28:0] cmd_out_TDATA,
  output logic        cmd_out_TVALID,
  input  logic        cmd_out_TREADY,
  input  logic [9:0]  fsm_state,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_ISSUE,
    S_WAIT_START,
    S_RUN
  } state_e;

  state_e      state_q, state_d;
  logic [28:0] data_q, data_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_q, last_d;         // 1: requester 1 was served last
  logic        zero_seen_q, zero_seen_d;
  logic        pick1;
  logic        expired;

  // Requester 1 wins when it is the only one valid, or on a tie when
  // requester 0 was the one served last.
  assign pick1 = cmd1_TVALID && (!cmd0_TVALID || !last_q);

`ifdef CMD_ARBITER_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts cycles spent in the current WAIT_START/RUN state; any state change
  // (including WAIT_START -> RUN) restarts it from zero.
  always_comb begin
    cnt_d = '0;
    if ((state_q == S_WAIT_START || state_q == S_RUN) && state_d == state_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired     = (state_q == S_WAIT_START || state_q == S_RUN) &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES));
  assign timeout_err = expired;
`else
  logic [31:0] unused_timeout_cfg;

  assign unused_timeout_cfg = TIMEOUT_CYCLES;
  assign expired            = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    grant_d     = grant_q;
    last_d      = last_q;
    zero_seen_d = 1'b0;
    cmd0_TREADY = 1'b0;
    cmd1_TREADY = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // TREADY is gated by rst so nothing is acknowledged while held in reset.
        if (!rst && (cmd0_TVALID || cmd1_TVALID)) begin
          cmd0_TREADY = !pick1;
          cmd1_TREADY = pick1;
          data_d      = pick1 ? cmd1_TDATA : cmd0_TDATA;
          grant_d     = pick1 ? 2'b10 : 2'b01;
          state_d     = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (data_q == '0) begin
          grant_d = '0;
          last_d  = grant_q[1];
          state_d = S_IDLE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_out_TREADY) begin
          state_d = S_WAIT_START;
        end
      end
      S_WAIT_START: begin
        // Two consecutive START cycles mean the FSM consumed the command
        // without leaving START.
        if (fsm_state != '0) begin
          state_d = S_RUN;
        end else if (zero_seen_q) begin
          grant_d = '0;
          last_d  = grant_q[1];
          state_d = S_IDLE;
        end else begin
          zero_seen_d = 1'b1;
        end
      end
      S_RUN: begin
        if (fsm_state == '0) begin
          grant_d = '0;
          last_d  = grant_q[1];
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase

    if (expired) begin
      grant_d     = '0;
      last_d      = grant_q[1];
      zero_seen_d = 1'b0;
      state_d     = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      grant_q     <= '0;
      last_q      <= 1'b1;
      zero_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      zero_seen_q <= zero_seen_d;
    end
  end

  assign cmd_out_TVALID = (state_q == S_ISSUE);
  assign cmd_out_TDATA  = cmd_out_TVALID ? data_q : '0;
  assign grant          = grant_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_cmd_arbiter.sv
// tb_cmd_arbiter: directed self-checking bench for cmd_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are sampled there or
// 1 unit later for the combinational TREADY paths.

module tb_cmd_arbiter;

  logic        clk;
  logic        rst;
  logic [28:0] cmd0_TDATA;
  logic        cmd0_TVALID;
  logic        cmd0_TREADY;
  logic [28:0] cmd1_TDATA;
  logic        cmd1_TVALID;
  logic        cmd1_TREADY;
  logic [28:0] cmd_out_TDATA;
  logic        cmd_out_TVALID;
  logic        cmd_out_TREADY;
  logic [9:0]  fsm_state;
  logic [1:0]  grant;
  logic        busy;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  cmd_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd0_TDATA     (cmd0_TDATA),
    .cmd0_TVALID    (cmd0_TVALID),
    .cmd0_TREADY    (cmd0_TREADY),
    .cmd1_TDATA     (cmd1_TDATA),
    .cmd1_TVALID    (cmd1_TVALID),
    .cmd1_TREADY    (cmd1_TREADY),
    .cmd_out_TDATA  (cmd_out_TDATA),
    .cmd_out_TVALID (cmd_out_TVALID),
    .cmd_out_TREADY (cmd_out_TREADY),
    .fsm_state      (fsm_state),
    .grant          (grant),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in IDLE with requesters already driven; ends back in IDLE.
  // FSM stub stays in START, so the op closes after two WAIT_START cycles.
  task automatic serve(input string tag, input logic [1:0] exp_g, input logic [28:0] exp_d);
    #1;
    check({tag, "_rdy0"}, 32'(cmd0_TREADY), 32'(exp_g[0]));
    check({tag, "_rdy1"}, 32'(cmd1_TREADY), 32'(exp_g[1]));
    tick();
    check({tag, "_grant"}, 32'(grant), 32'(exp_g));
    check({tag, "_busy_rdy"}, 32'({cmd0_TREADY, cmd1_TREADY}), 32'(0));
    tick();
    check({tag, "_vld"}, 32'(cmd_out_TVALID), 32'(1));
    check({tag, "_data"}, 32'(cmd_out_TDATA), 32'(exp_d));
    tick();
    check({tag, "_ws_vld"}, 32'(cmd_out_TVALID), 32'(0));
    check({tag, "_ws_busy"}, 32'(busy), 32'(1));
    tick();
    check({tag, "_ws2_busy"}, 32'(busy), 32'(1));
    tick();
    check({tag, "_idle_busy"}, 32'(busy), 32'(0));
    check({tag, "_idle_grant"}, 32'(grant), 32'(0));
  endtask

  initial begin
    rst            = 1'b1;
    cmd0_TDATA     = '0;
    cmd0_TVALID    = 1'b0;
    cmd1_TDATA     = '0;
    cmd1_TVALID    = 1'b0;
    cmd_out_TREADY = 1'b0;
    fsm_state      = '0;
    tick();
    tick();

    // Reset values
    check("rst_grant", 32'(grant), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_vld", 32'(cmd_out_TVALID), 32'(0));
    check("rst_data", 32'(cmd_out_TDATA), 32'(0));
    check("rst_rdy", 32'({cmd0_TREADY, cmd1_TREADY}), 32'(0));
    check("rst_tmo", 32'(timeout_err), 32'(0));
    rst = 1'b0;
    tick();

    // cmd0 alone, FSM goes to state 1 for 5 cycles
    cmd_out_TREADY = 1'b1;
    cmd0_TDATA     = 29'h0000009;
    cmd0_TVALID    = 1'b1;
    #1;
    check("c0_rdy0", 32'(cmd0_TREADY), 32'(1));
    check("c0_rdy1", 32'(cmd1_TREADY), 32'(0));
    check("c0_idle_vld", 32'(cmd_out_TVALID), 32'(0));
    tick();
    cmd0_TVALID = 1'b0;
    check("c0_cap_grant", 32'(grant), 32'(1));
    check("c0_cap_busy", 32'(busy), 32'(1));
    check("c0_cap_vld", 32'(cmd_out_TVALID), 32'(0));
    tick();
    check("c0_iss_vld", 32'(cmd_out_TVALID), 32'(1));
    check("c0_iss_data", 32'(cmd_out_TDATA), 32'(9));
    tick();
    fsm_state = 10'd1;
    check("c0_ws_vld", 32'(cmd_out_TVALID), 32'(0));
    check("c0_ws_data", 32'(cmd_out_TDATA), 32'(0));
    tick();
    check("c0_run_busy", 32'(busy), 32'(1));
    check("c0_run_grant", 32'(grant), 32'(1));
    repeat (3) tick();
    check("c0_run_grant2", 32'(grant), 32'(1));
    fsm_state = '0;
    tick();
    check("c0_done_busy", 32'(busy), 32'(0));
    check("c0_done_grant", 32'(grant), 32'(0));

    // cmd1 with zero word is accepted then discarded
    cmd1_TDATA  = '0;
    cmd1_TVALID = 1'b1;
    #1;
    check("z1_rdy1", 32'(cmd1_TREADY), 32'(1));
    check("z1_rdy0", 32'(cmd0_TREADY), 32'(0));
    tick();
    cmd1_TVALID = 1'b0;
    check("z1_cap_grant", 32'(grant), 32'(2));
    check("z1_cap_vld", 32'(cmd_out_TVALID), 32'(0));
    tick();
    check("z1_end_grant", 32'(grant), 32'(0));
    check("z1_end_busy", 32'(busy), 32'(0));
    check("z1_end_vld", 32'(cmd_out_TVALID), 32'(0));

    // Downstream stall for 10 cycles; cmd1 waits then drops its request
    cmd_out_TREADY = 1'b0;
    cmd0_TDATA     = 29'h0000009;
    cmd0_TVALID    = 1'b1;
    #1;
    check("st_rdy0", 32'(cmd0_TREADY), 32'(1));
    tick();
    cmd0_TVALID = 1'b0;
    cmd1_TDATA  = 29'h33;
    cmd1_TVALID = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      #1;
      check("st_vld", 32'(cmd_out_TVALID), 32'(1));
      check("st_data", 32'(cmd_out_TDATA), 32'(9));
      check("st_rdy1", 32'(cmd1_TREADY), 32'(0));
      tick();
    end
    cmd_out_TREADY = 1'b1;
    cmd1_TVALID    = 1'b0;
    tick();
    check("st_ws_vld", 32'(cmd_out_TVALID), 32'(0));
    tick();
    tick();
    check("st_idle_busy", 32'(busy), 32'(0));
    tick();
    check("st_drop_busy", 32'(busy), 32'(0));
    check("st_drop_grant", 32'(grant), 32'(0));

    // Round-robin ties from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    cmd0_TDATA  = 29'h11;
    cmd1_TDATA  = 29'h21;
    cmd0_TVALID = 1'b1;
    cmd1_TVALID = 1'b1;
    serve("tie1", 2'b01, 29'h11);
    serve("tie2", 2'b10, 29'h21);
    serve("tie3", 2'b01, 29'h11);
    cmd1_TVALID = 1'b0;

    // Reset during RUN abandons the command
    cmd0_TDATA = 29'h55;
    #1;
    tick();
    tick();
    tick();
    fsm_state = 10'd3;
    tick();
    check("rr_run_busy", 32'(busy), 32'(1));
    check("rr_run_rdy0", 32'(cmd0_TREADY), 32'(0));
    rst = 1'b1;
    #1;
    check("rr_grant", 32'(grant), 32'(0));
    check("rr_busy", 32'(busy), 32'(0));
    check("rr_vld", 32'(cmd_out_TVALID), 32'(0));
    check("rr_data", 32'(cmd_out_TDATA), 32'(0));
    check("rr_rdy", 32'({cmd0_TREADY, cmd1_TREADY}), 32'(0));
    check("rr_tmo", 32'(timeout_err), 32'(0));
    cmd0_TVALID = 1'b0;
    fsm_state   = '0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rr_no_replay", 32'(cmd_out_TVALID), 32'(0));
      check("rr_idle", 32'(busy), 32'(0));
    end

`ifdef CMD_ARBITER_TIMEOUT_EN
    // Watchdog: FSM stuck in state 4
    cmd0_TDATA  = 29'h77;
    cmd0_TVALID = 1'b1;
    #1;
    tick();
    cmd0_TVALID = 1'b0;
    tick();
    tick();
    fsm_state = 10'd4;
    tick();
    for (int k = 0; k < 16; k++) begin
      check("to_quiet", 32'(timeout_err), 32'(0));
      tick();
    end
    check("to_pulse", 32'(timeout_err), 32'(1));
    check("to_pulse_busy", 32'(busy), 32'(1));
    tick();
    check("to_after_busy", 32'(busy), 32'(0));
    check("to_after_pulse", 32'(timeout_err), 32'(0));
    check("to_after_grant", 32'(grant), 32'(0));
    fsm_state = '0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
